// File: rtl/netwalk_flow_programmer_pkg.sv
// Shared widths, opcodes, status codes and FSM encoding for the flow-table programmer.
package netwalk_flow_programmer_pkg;

    localparam int unsigned MatchWidth = 356;
    localparam int unsigned FlagWidth  = 16;
    localparam int unsigned SetWidth   = 356;
    localparam int unsigned ExecWidth  = FlagWidth + SetWidth;
    localparam int unsigned AddrWidth  = 6;
    localparam int unsigned NumSlots   = 2 ** AddrWidth;
    localparam int unsigned CountWidth = AddrWidth + 1;

    localparam logic [1:0] StatusOk       = 2'b00;
    localparam logic [1:0] StatusFull     = 2'b01;
    localparam logic [1:0] StatusNotFound = 2'b10;

    localparam logic OpAdd    = 1'b0;
    localparam logic OpDelete = 1'b1;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAlloc,
        StWrite,
        StErase,
        StResp
    } state_e;

endpackage

// File: rtl/netwalk_flow_programmer_slot_allocator.sv
// Slot occupancy bitmap with set/clear ports, lowest-free-slot encoder and
// a registered count of occupied slots.
module netwalk_flow_programmer_slot_allocator
    import netwalk_flow_programmer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_set,
    input  logic [AddrWidth-1:0]  i_set_idx,
    input  logic                  i_clear,
    input  logic [AddrWidth-1:0]  i_clear_idx,
    output logic [NumSlots-1:0]   o_map,
    output logic                  o_free_valid,
    output logic [AddrWidth-1:0]  o_free_idx,
    output logic [CountWidth-1:0] o_count
);

    logic [NumSlots-1:0]   r_map;
    logic [NumSlots-1:0]   w_map_next;
    logic [CountWidth-1:0] r_count;
    logic                  w_inc;
    logic                  w_dec;

    // Count only real transitions so a repeated set/clear cannot skew the total.
    assign w_inc = i_set & ~r_map[i_set_idx];
    assign w_dec = i_clear & r_map[i_clear_idx];

    always_comb begin
        w_map_next = r_map;
        if (i_set) begin
            w_map_next[i_set_idx] = 1'b1;
        end
        if (i_clear) begin
            w_map_next[i_clear_idx] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_map   <= '0;
            r_count <= '0;
        end else begin
            r_map   <= w_map_next;
            r_count <= r_count + CountWidth'(w_inc) - CountWidth'(w_dec);
        end
    end

    // Scan high to low so the lowest free index is the last one written.
    always_comb begin
        o_free_valid = 1'b0;
        o_free_idx   = '0;
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            if (!r_map[i]) begin
                o_free_valid = 1'b1;
                o_free_idx   = AddrWidth'(i);
            end
        end
    end

    assign o_map   = r_map;
    assign o_count = r_count;

endmodule

// File: rtl/netwalk_flow_programmer.sv
// Flow-mod command front end: clears every TCAM/exec slot after reset, then
// serves ADD/DELETE commands as single-cycle program/delete pulses to the core.
module netwalk_flow_programmer
    import netwalk_flow_programmer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_op,
    input  logic [AddrWidth-1:0]  i_cmd_addr,
    input  logic [MatchWidth-1:0] i_cmd_match,
    input  logic [MatchWidth-1:0] i_cmd_mask,
    input  logic [ExecWidth-1:0]  i_cmd_action,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [1:0]            o_resp_status,
    output logic [AddrWidth-1:0]  o_resp_addr,
    output logic [MatchWidth-1:0] o_tcam_program_data,
    output logic [MatchWidth-1:0] o_tcam_program_mask,
    output logic [AddrWidth-1:0]  o_tcam_program_addr,
    output logic                  o_tcam_program_enable,
    output logic                  o_tcam_delete_enable,
    output logic [ExecWidth-1:0]  o_exec_program_data,
    output logic [AddrWidth-1:0]  o_exec_program_addr,
    output logic                  o_exec_program_enable,
    output logic                  o_exec_delete_enable,
    output logic [CountWidth-1:0] o_flow_entries,
    output logic                  o_init_done
);

    state_e                r_state;
    state_e                w_state_next;
    logic [CountWidth-1:0] r_sweep;

    logic [MatchWidth-1:0] r_cmd_match;
    logic [MatchWidth-1:0] r_cmd_mask;
    logic [ExecWidth-1:0]  r_cmd_action;
    logic [MatchWidth-1:0] r_tcam_data;
    logic [MatchWidth-1:0] r_tcam_mask;
    logic [ExecWidth-1:0]  r_exec_data;
    logic [AddrWidth-1:0]  r_core_addr;
    logic                  r_prog_en;
    logic                  r_del_en;
    logic                  r_init_done;
    logic [1:0]            r_resp_status;
    logic [AddrWidth-1:0]  r_resp_addr;

    logic                  w_prog_en;
    logic                  w_del_en;
    logic [AddrWidth-1:0]  w_core_addr;
    logic                  w_init_done;
    logic [1:0]            w_resp_status;
    logic [AddrWidth-1:0]  w_resp_addr;
    logic                  w_cmd_load;
    logic                  w_set;
    logic                  w_clear;
    logic [NumSlots-1:0]   w_map;
    logic                  w_free_valid;
    logic [AddrWidth-1:0]  w_free_idx;

    netwalk_flow_programmer_slot_allocator u_alloc (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_set        (w_set),
        .i_set_idx    (w_free_idx),
        .i_clear      (w_clear),
        .i_clear_idx  (i_cmd_addr),
        .o_map        (w_map),
        .o_free_valid (w_free_valid),
        .o_free_idx   (w_free_idx),
        .o_count      (o_flow_entries)
    );

    // r_sweep[AddrWidth] marks the end of the clear sweep.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StInit;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StInit && !r_sweep[AddrWidth]) begin
                r_sweep <= r_sweep + CountWidth'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StInit:  if (r_sweep[AddrWidth]) w_state_next = StIdle;
            StIdle:  if (i_cmd_valid) w_state_next = (i_cmd_op == OpDelete) ? StErase : StAlloc;
            StAlloc: w_state_next = w_free_valid ? StWrite : StResp;
            StWrite: w_state_next = StResp;
            StErase: w_state_next = StResp;
            StResp:  if (i_resp_ready) w_state_next = StIdle;
            default: w_state_next = StInit;
        endcase
    end

    // Core-port values are computed here and registered, so each pulse lines up
    // with the WRITE/ERASE state it belongs to.
    always_comb begin
        o_cmd_ready   = (r_state == StIdle);
        o_resp_valid  = (r_state == StResp);
        w_prog_en     = 1'b0;
        w_del_en      = 1'b0;
        w_core_addr   = r_core_addr;
        w_init_done   = r_init_done;
        w_resp_status = r_resp_status;
        w_resp_addr   = r_resp_addr;
        w_cmd_load    = 1'b0;
        w_set         = 1'b0;
        w_clear       = 1'b0;
        unique case (r_state)
            StInit: begin
                if (!r_sweep[AddrWidth]) begin
                    w_del_en    = 1'b1;
                    w_core_addr = r_sweep[AddrWidth-1:0];
                end else begin
                    w_init_done = 1'b1;
                end
            end
            StIdle: begin
                if (i_cmd_valid) begin
                    w_cmd_load = 1'b1;
                    if (i_cmd_op == OpDelete) begin
                        w_resp_addr = i_cmd_addr;
                        if (w_map[i_cmd_addr]) begin
                            w_del_en      = 1'b1;
                            w_core_addr   = i_cmd_addr;
                            w_clear       = 1'b1;
                            w_resp_status = StatusOk;
                        end else begin
                            w_resp_status = StatusNotFound;
                        end
                    end
                end
            end
            StAlloc: begin
                if (w_free_valid) begin
                    w_prog_en     = 1'b1;
                    w_core_addr   = w_free_idx;
                    w_set         = 1'b1;
                    w_resp_status = StatusOk;
                    w_resp_addr   = w_free_idx;
                end else begin
                    w_resp_status = StatusFull;
                    w_resp_addr   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd_match   <= '0;
            r_cmd_mask    <= '0;
            r_cmd_action  <= '0;
            r_tcam_data   <= '0;
            r_tcam_mask   <= '0;
            r_exec_data   <= '0;
            r_core_addr   <= '0;
            r_prog_en     <= 1'b0;
            r_del_en      <= 1'b0;
            r_init_done   <= 1'b0;
            r_resp_status <= '0;
            r_resp_addr   <= '0;
        end else begin
            r_core_addr   <= w_core_addr;
            r_prog_en     <= w_prog_en;
            r_del_en      <= w_del_en;
            r_init_done   <= w_init_done;
            r_resp_status <= w_resp_status;
            r_resp_addr   <= w_resp_addr;
            if (w_cmd_load) begin
                r_cmd_match  <= i_cmd_match;
                r_cmd_mask   <= i_cmd_mask;
                r_cmd_action <= i_cmd_action;
            end
            if (w_prog_en) begin
                r_tcam_data <= r_cmd_match;
                r_tcam_mask <= r_cmd_mask;
                r_exec_data <= r_cmd_action;
            end
        end
    end

    assign o_tcam_program_data   = r_tcam_data;
    assign o_tcam_program_mask   = r_tcam_mask;
    assign o_tcam_program_addr   = r_core_addr;
    assign o_tcam_program_enable = r_prog_en;
    assign o_tcam_delete_enable  = r_del_en;
    assign o_exec_program_data   = r_exec_data;
    assign o_exec_program_addr   = r_core_addr;
    assign o_exec_program_enable = r_prog_en;
    assign o_exec_delete_enable  = r_del_en;
    assign o_resp_status         = r_resp_status;
    assign o_resp_addr           = r_resp_addr;
    assign o_init_done           = r_init_done;

endmodule

// File: tb/tb_netwalk_flow_programmer.sv
// Randomized bench for netwalk_flow_programmer: a slot-array model predicts every
// output each cycle, plus literal checks on the directed scenarios.
module tb_netwalk_flow_programmer;

    localparam int W = 372;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic         i_cmd_op = 1'b0;
    logic [5:0]   i_cmd_addr = '0;
    logic [355:0] i_cmd_match = '0;
    logic [355:0] i_cmd_mask = '0;
    logic [371:0] i_cmd_action = '0;
    logic         o_resp_valid;
    logic         i_resp_ready = 1'b0;
    logic [1:0]   o_resp_status;
    logic [5:0]   o_resp_addr;
    logic [355:0] o_tcam_program_data;
    logic [355:0] o_tcam_program_mask;
    logic [5:0]   o_tcam_program_addr;
    logic         o_tcam_program_enable;
    logic         o_tcam_delete_enable;
    logic [371:0] o_exec_program_data;
    logic [5:0]   o_exec_program_addr;
    logic         o_exec_program_enable;
    logic         o_exec_delete_enable;
    logic [6:0]   o_flow_entries;
    logic         o_init_done;

    netwalk_flow_programmer dut (
        .i_clk                 (clk),
        .i_reset               (i_reset),
        .i_cmd_valid           (i_cmd_valid),
        .o_cmd_ready           (o_cmd_ready),
        .i_cmd_op              (i_cmd_op),
        .i_cmd_addr            (i_cmd_addr),
        .i_cmd_match           (i_cmd_match),
        .i_cmd_mask            (i_cmd_mask),
        .i_cmd_action          (i_cmd_action),
        .o_resp_valid          (o_resp_valid),
        .i_resp_ready          (i_resp_ready),
        .o_resp_status         (o_resp_status),
        .o_resp_addr           (o_resp_addr),
        .o_tcam_program_data   (o_tcam_program_data),
        .o_tcam_program_mask   (o_tcam_program_mask),
        .o_tcam_program_addr   (o_tcam_program_addr),
        .o_tcam_program_enable (o_tcam_program_enable),
        .o_tcam_delete_enable  (o_tcam_delete_enable),
        .o_exec_program_data   (o_exec_program_data),
        .o_exec_program_addr   (o_exec_program_addr),
        .o_exec_program_enable (o_exec_program_enable),
        .o_exec_delete_enable  (o_exec_delete_enable),
        .o_flow_entries        (o_flow_entries),
        .o_init_done           (o_init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: which slots hold a flow, plus what each output must show now.
    bit   [63:0]  occ;
    logic         exp_cmd_ready, exp_init_done, exp_prog, exp_del, exp_resp_valid;
    logic [5:0]   exp_addr, exp_resp_addr;
    logic [1:0]   exp_resp_status;
    logic [355:0] exp_tdata, exp_tmask;
    logic [371:0] exp_edata;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pop();
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(occ[i]);
        return 7'(c);
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < 64; i++) if (!occ[i]) return i;
        return -1;
    endfunction

    function automatic logic [371:0] rnd_word();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        return t[371:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", W'(o_cmd_ready), W'(exp_cmd_ready));
            chk("init_done", W'(o_init_done), W'(exp_init_done));
            chk("flow_entries", W'(o_flow_entries), W'(pop()));
            chk("tcam_prog_en", W'(o_tcam_program_enable), W'(exp_prog));
            chk("exec_prog_en", W'(o_exec_program_enable), W'(exp_prog));
            chk("tcam_del_en", W'(o_tcam_delete_enable), W'(exp_del));
            chk("exec_del_en", W'(o_exec_delete_enable), W'(exp_del));
            chk("tcam_addr", W'(o_tcam_program_addr), W'(exp_addr));
            chk("exec_addr", W'(o_exec_program_addr), W'(exp_addr));
            chk("tcam_data", W'(o_tcam_program_data), W'(exp_tdata));
            chk("tcam_mask", W'(o_tcam_program_mask), W'(exp_tmask));
            chk("exec_data", W'(o_exec_program_data), W'(exp_edata));
            chk("resp_valid", W'(o_resp_valid), W'(exp_resp_valid));
            if (exp_resp_valid) begin
                chk("resp_status", W'(o_resp_status), W'(exp_resp_status));
                chk("resp_addr", W'(o_resp_addr), W'(exp_resp_addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for n edges, then follows the 64-slot clear sweep to IDLE.
    task automatic do_reset(input int n);
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        i_resp_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            chk_en = 1'b1;
            occ = '0;
            exp_cmd_ready = 0; exp_init_done = 0; exp_prog = 0; exp_del = 0;
            exp_resp_valid = 0; exp_addr = '0; exp_tdata = '0; exp_tmask = '0; exp_edata = '0;
            exp_resp_status = '0; exp_resp_addr = '0;
        end
        i_reset = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            exp_del = 1'b1;
            exp_addr = 6'(k);
        end
        tick();
        exp_del = 1'b0;
        exp_init_done = 1'b1;
        exp_cmd_ready = 1'b1;
    endtask

    // Entered in the first RESP cycle; holds resp_ready low for 'delay' cycles.
    task automatic resp_phase(input int delay, output logic [1:0] st, output logic [5:0] ad);
        exp_resp_valid = 1'b1;
        st = o_resp_status;
        ad = o_resp_addr;
        for (int d = 0; d < delay; d++) begin
            i_resp_ready = 1'b0;
            tick();
        end
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        exp_resp_valid = 1'b0;
        exp_cmd_ready = 1'b1;
    endtask

    task automatic issue(input logic op, input logic [5:0] a, input logic [355:0] m,
                         input logic [355:0] mk, input logic [371:0] act);
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_addr = a;
        i_cmd_match = m;
        i_cmd_mask = mk;
        i_cmd_action = act;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_addr = 6'($urandom);
        i_cmd_match = rnd_word()[355:0];
        exp_cmd_ready = 1'b0;
    endtask

    // ADD: returns once the response is consumed; abort=1 asserts reset in WRITE.
    task automatic do_add(input logic [355:0] m, input logic [355:0] mk, input logic [371:0] act,
                          input int delay, input bit abort,
                          output logic [1:0] st, output logic [5:0] ad);
        int f;
        f = lowest_free();
        issue(1'b0, 6'($urandom), m, mk, act);
        tick();
        if (f >= 0) begin
            occ[f] = 1'b1;
            exp_prog = 1'b1;
            exp_addr = 6'(f);
            exp_tdata = m;
            exp_tmask = mk;
            exp_edata = act;
            exp_resp_status = 2'b00;
            exp_resp_addr = 6'(f);
            if (abort) begin
                st = 2'b11;
                ad = '0;
                do_reset(2);
                return;
            end
            tick();
            exp_prog = 1'b0;
        end else begin
            exp_resp_status = 2'b01;
            exp_resp_addr = 6'd0;
        end
        resp_phase(delay, st, ad);
    endtask

    task automatic do_delete(input logic [5:0] a, input int delay,
                             output logic [1:0] st, output logic [5:0] ad);
        bit hit;
        hit = occ[a];
        issue(1'b1, a, rnd_word()[355:0], rnd_word()[355:0], rnd_word());
        exp_resp_addr = a;
        if (hit) begin
            occ[a] = 1'b0;
            exp_del = 1'b1;
            exp_addr = a;
            exp_resp_status = 2'b00;
        end else begin
            exp_resp_status = 2'b10;
        end
        tick();
        exp_del = 1'b0;
        resp_phase(delay, st, ad);
    endtask

    logic [1:0]   st;
    logic [5:0]   ad;
    logic [355:0] pat;
    logic [383:0] pat_wide;

    initial begin
        occ = '0;
        do_reset(3);
        chk("pin_init_done", W'(o_init_done), W'(1'b1));
        chk("pin_init_ready", W'(o_cmd_ready), W'(1'b1));

        pat_wide = {12{32'h06a506a5}};
        pat = pat_wide[355:0];
        for (int k = 0; k < 3; k++) begin
            do_add(pat, '1, {16'h0001, pat}, 0, 1'b0, st, ad);
            chk("pin_add_status", W'(st), W'(2'b00));
            chk("pin_add_addr", W'(ad), W'(k));
        end
        chk("pin_flow3", W'(o_flow_entries), W'(3));

        do_delete(6'd1, 1, st, ad);
        chk("pin_del1_status", W'(st), W'(2'b00));
        do_add(pat, '1, rnd_word(), 0, 1'b0, st, ad);
        chk("pin_reuse_addr", W'(ad), W'(1));
        chk("pin_reuse_flow", W'(o_flow_entries), W'(3));

        while (pop() < 7'd64) begin
            do_add(rnd_word()[355:0], rnd_word()[355:0], rnd_word(), $urandom_range(0, 2), 1'b0, st, ad);
        end
        do_add(rnd_word()[355:0], '1, rnd_word(), 0, 1'b0, st, ad);
        chk("pin_full_status", W'(st), W'(2'b01));
        chk("pin_full_addr", W'(ad), W'(0));
        chk("pin_full_flow", W'(o_flow_entries), W'(64));

        do_delete(6'd5, 0, st, ad);
        do_delete(6'd5, 10, st, ad);
        chk("pin_nf_status", W'(st), W'(2'b10));
        chk("pin_nf_flow", W'(o_flow_entries), W'(63));

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 99) < 55) begin
                do_add(rnd_word()[355:0], rnd_word()[355:0], rnd_word(), $urandom_range(0, 3), 1'b0,
                       st, ad);
            end else begin
                do_delete(6'($urandom_range(0, 63)), $urandom_range(0, 3), st, ad);
            end
        end

        do_delete(6'd63, 0, st, ad);
        do_add(rnd_word()[355:0], rnd_word()[355:0], rnd_word(), 0, 1'b1, st, ad);
        chk("pin_abort_flow", W'(o_flow_entries), W'(0));
        chk("pin_abort_init", W'(o_init_done), W'(1'b1));
        do_add(pat, '1, rnd_word(), 0, 1'b0, st, ad);
        chk("pin_post_reset_addr", W'(ad), W'(0));
        chk("pin_post_reset_flow", W'(o_flow_entries), W'(1));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
